// File: rtl/dma_regs_pkg.sv
// Shared definitions for the DMA configuration register map and the AXI-Lite
// register master that programs it.
package dma_regs_pkg;

    // Register byte offsets of the DMA configuration slave
    localparam logic [5:0] CTRL      = 6'h00;
    localparam logic [5:0] INTR_EN   = 6'h04;
    localparam logic [5:0] INTR_STAT = 6'h0C;
    localparam logic [5:0] RADDR     = 6'h10;
    localparam logic [5:0] WADDR     = 6'h20;
    localparam logic [5:0] BTT       = 6'h30;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrB,
        StRdAr,
        StRdR,
        StRsp
    } axil_mst_state_t;

endpackage

// File: rtl/axil_reg_master.sv
// AXI4-Lite initiator: turns a command/response stream into single register
// transactions, one outstanding at a time, and counts error responses.
module axil_reg_master
    import dma_regs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 6,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]  cmd_wstrb,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    m_awaddr,
    output logic [2:0]               m_awprot,
    output logic                     m_awvalid,
    input  logic                     m_awready,
    output logic [DATA_WIDTH-1:0]    m_wdata,
    output logic [DATA_WIDTH/8-1:0]  m_wstrb,
    output logic                     m_wvalid,
    input  logic                     m_wready,
    input  logic [1:0]               m_bresp,
    input  logic                     m_bvalid,
    output logic                     m_bready,
    output logic [ADDR_WIDTH-1:0]    m_araddr,
    output logic [2:0]               m_arprot,
    output logic                     m_arvalid,
    input  logic                     m_arready,
    input  logic [DATA_WIDTH-1:0]    m_rdata,
    input  logic [1:0]               m_rresp,
    input  logic                     m_rvalid,
    output logic                     m_rready
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("axil_reg_master: DATA_WIDTH must be 32");
    end

    axil_mst_state_t state_q, state_d;

    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     arvalid_q, arvalid_d;
    logic                     bready_q, bready_d;
    logic                     rready_q, rready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [1:0]               rsp_resp_q, rsp_resp_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH/8-1:0]  wstrb_q;
    logic                     write_q;

    logic       accept;
    logic       aw_done;
    logic       w_done;
    logic       resp_cap;
    logic [1:0] cap_resp;

    assign cmd_ready = (state_q == StIdle) & rstn;
    assign accept    = cmd_valid & cmd_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            err_count_q <= err_count_d;
        end
    end

    // Command payload is only loaded in IDLE, so it stays stable while any VALID is high.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            write_q <= cmd_write;
        end
    end

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        err_count_d = err_count_q;
        resp_cap    = 1'b0;
        cap_resp    = RESP_OKAY;
        // A channel is done once its VALID has dropped or is handshaking now.
        aw_done     = ~awvalid_q | m_awready;
        w_done      = ~wvalid_q | m_wready;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cmd_write) begin
                        state_d   = StWr;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRdAr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWr: begin
                if (m_awready) awvalid_d = 1'b0;
                if (m_wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = StWrB;
                    bready_d = 1'b1;
                end
            end
            StWrB: begin
                if (m_bvalid) begin
                    state_d     = StRsp;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_bresp;
                    resp_cap    = 1'b1;
                    cap_resp    = m_bresp;
                end
            end
            StRdAr: begin
                if (m_arready) begin
                    state_d   = StRdR;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRdR: begin
                if (m_rvalid) begin
                    state_d     = StRsp;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_rdata;
                    rsp_resp_d  = m_rresp;
                    resp_cap    = 1'b1;
                    cap_resp    = m_rresp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (resp_cap && cap_resp != RESP_OKAY && err_count_q != '1) begin
            err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign err_count = err_count_q;

    assign m_awaddr  = addr_q;
    assign m_awprot  = 3'b000;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_araddr  = addr_q;
    assign m_arprot  = 3'b000;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule

// File: doc/axil_reg_master.md
Name: axil_reg_master

Overview:
- AXI4-Lite initiator that turns a simple command/response stream into single register transactions.
- It is the host-side counterpart of the DMA configuration register slave, used by on-chip sequencers and testbench drivers to program read_start_addr, write_start_addr, btt and control, and to poll status.
- One transaction is outstanding at a time.
- It counts non-OKAY responses in a saturating counter.

Parameters:
- ADDR_WIDTH, 6, width of cmd_addr and the AXI-Lite address buses.
- DATA_WIDTH, 32, data width; fixed at 32, any other value is a static elaboration error.
- ERR_CNT_WIDTH, 16, width of the error counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  register byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echoes cmd_write of the completed transaction
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP of the transaction
- err_count  out  ERR_CNT_WIDTH  saturating count of resp != 2'b00
- m_awaddr  out  ADDR_WIDTH
- m_awprot  out  3  constant 3'b000
- m_awvalid  out  1
- m_awready  in  1
- m_wdata  out  32
- m_wstrb  out  4
- m_wvalid  out  1
- m_wready  in  1
- m_bresp  in  2
- m_bvalid  in  1
- m_bready  out  1
- m_araddr  out  ADDR_WIDTH
- m_arprot  out  3  constant 3'b000
- m_arvalid  out  1
- m_arready  in  1
- m_rdata  in  32
- m_rresp  in  2
- m_rvalid  in  1
- m_rready  out  1

Behaviour:
- FSM states: IDLE, WR (AW/W phase), WR_B, RD_AR, RD_R, RSP. All outputs are registered except cmd_ready = (state==IDLE) & rstn, which is combinational.
- Reset (rstn low at a posedge):
  - state goes to IDLE.
  - m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready and rsp_valid go to 0.
  - err_count goes to 0.
  - rsp_rdata and rsp_resp go to 0.
  - Address and data registers are not reset.
  - Reset mid-transaction abandons it silently, with no response. The slave is reset by the same rstn.
- IDLE: on cmd_valid&cmd_ready, capture addr, wdata, wstrb and write.
  - Write goes to WR with m_awvalid=1 and m_wvalid=1 from the next cycle (1-cycle latency).
  - Read goes to RD_AR with m_arvalid=1.
- WR: m_awvalid and m_wvalid deassert independently on their own handshake. Internal flags aw_done and w_done record completion.
  - Either order is legal, as is both in the same cycle.
  - The slave accepts AW first and W one or more cycles later. This is the normal case.
  - When both are done (including via a same-cycle handshake), go to WR_B with m_bready=1.
  - VALID never drops before READY.
  - Address, data and strobes are stable while their VALID is high.
- WR_B: on m_bvalid, capture m_bresp into rsp_resp, set rsp_rdata=0, go to RSP, m_bready=0.
- RD_AR: hold m_arvalid until m_arready. Then go to RD_R with m_rready=1.
- RD_R: on m_rvalid, capture m_rdata and m_rresp, go to RSP, m_rready=0.
- RSP: rsp_valid=1 and held stable until rsp_ready, then go to IDLE.
  - The earliest new cmd acceptance is the cycle after rsp_valid&rsp_ready.
  - rsp_valid and cmd_ready are never high together.
- err_count increments by 1 at the cycle the response is captured (B or R handshake) when resp != 2'b00. It saturates at all-ones and does not wrap.
- No timeout. A hung slave holds the FSM in WR_B or RD_R until reset.
- Minimum transaction latency against a zero-wait slave:
  - write: cmd accept → rsp_valid in 3 cycles plus the slave's added latency.
  - read: the same structure applies.

Decomposition:
- Package dma_regs_pkg holds:
  - the register offset localparams: CTRL=6'h00, INTR_EN=6'h04, INTR_STAT=6'h0C, RADDR=6'h10, WADDR=6'h20, BTT=6'h30;
  - the response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the state enum axil_mst_state_t.
- No sub-module; a single FSM is natural.

Test Plan:
- Write 0x10 data 0x8000_0000 strb 4'hF to the DMA config slave → AW accepted before W, rsp_write=1, rsp_resp=2'b00, readback of 0x10 gives 0x8000_0000.
- Read 0x00 after writing 0x100 → rsp_rdata=0x2D00_0100, rsp_resp=2'b00, err_count=0.
- Read 0x3C with BTT_WIDTH=32 → rsp_rdata=0x3BAD_ADD2, rsp_resp=2'b10, err_count=1. Force err_count to all-ones first → it stays all-ones.
- Behavioral slave with W ready before AW, then both in the same cycle → exactly one AW and one W handshake each, one response.
- rsp_ready held low 10 cycles → rsp_valid and data stable, cmd_ready=0. Then back-to-back commands with rsp_ready=1 → one transaction per response, no overlap.
- rstn low while in WR_B → next cycle all VALIDs and READYs are 0, no rsp_valid, cmd_ready=1 once rstn is high.
